// File: rtl/seq_div16.sv
// Iterative restoring divider that borrows the shared add/sub unit for every trial subtraction.
// Optional signed operation is compiled in with `define SEQ_DIV_SIGNED_EN.
module seq_div16 #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_is_sub,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_IN,
        S_RUN,
        S_NEG_OUT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_signed;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quot_o;
    logic [WIDTH-1:0] r_rem_o;
    logic             r_dz;

    state_t           w_state_nxt;
    logic [4:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic [WIDTH-1:0] w_dvs_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_accept;
    logic             w_load_out;
    logic             w_dz;
    logic             w_sgn;
    logic [WIDTH-1:0] w_r16;
    logic             w_ok;

`ifdef SEQ_DIV_SIGNED_EN
    assign w_sgn = is_signed;
`else
    assign w_sgn = is_signed & 1'b0;
`endif

    // The 17th bit of the shifted remainder lives in r_rem's MSB; if set, the subtraction always fits.
    assign w_r16 = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_ok  = r_rem[WIDTH-1] | add_cout;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_rem_nxt   = r_rem;
        w_accept    = 1'b0;
        w_load_out  = 1'b0;
        w_dz        = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        add_is_sub  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_sgn ? S_NEG_IN : S_RUN;
                    w_dvd_nxt   = dividend;
                    w_dvs_nxt   = divisor;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_NEG_IN: begin
                add_is_sub = 1'b1;
                add_cin    = 1'b1;
                if (r_cnt == 5'd0) begin
                    add_b = r_dvd;
                    if (r_dvs == '0) begin
                        w_state_nxt = S_DONE;
                        w_load_out  = 1'b1;
                        w_dz        = 1'b1;
                    end else begin
                        if (r_dvd[WIDTH-1]) w_dvd_nxt = add_sum;
                        w_cnt_nxt = 5'd1;
                    end
                end else begin
                    add_b = r_dvs;
                    if (r_dvs[WIDTH-1]) w_dvs_nxt = add_sum;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                add_a      = w_r16;
                add_b      = r_dvs;
                add_is_sub = 1'b1;
                add_cin    = 1'b1;
                // Count 0 screens for a zero divisor; counts 1..ITER are the restoring iterations.
                if (r_cnt == 5'd0) begin
                    if (r_dvs == '0) begin
                        w_state_nxt = S_DONE;
                        w_load_out  = 1'b1;
                        w_dz        = 1'b1;
                    end else begin
                        w_cnt_nxt = 5'd1;
                    end
                end else begin
                    w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ok};
                    w_rem_nxt = w_ok ? add_sum : w_r16;
                    if (r_cnt == 5'(ITER)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_signed ? S_NEG_OUT : S_DONE;
                        w_load_out  = !r_signed;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end

            S_NEG_OUT: begin
                add_is_sub = 1'b1;
                add_cin    = 1'b1;
                if (r_cnt == 5'd0) begin
                    add_b = r_dvd;
                    if (r_neg_q) w_dvd_nxt = add_sum;
                    w_cnt_nxt = 5'd1;
                end else begin
                    add_b = r_rem;
                    if (r_neg_r) w_rem_nxt = add_sum;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                    w_load_out  = 1'b1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quot_o <= '0;
            r_rem_o  <= '0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dvd   <= w_dvd_nxt;
            r_dvs   <= w_dvs_nxt;
            r_rem   <= w_rem_nxt;
            if (w_accept) begin
                r_signed <= w_sgn;
                r_neg_q  <= w_sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r  <= w_sgn & dividend[WIDTH-1];
                r_dz     <= 1'b0;
            end
            // A zero divisor reports all-ones and hands back the untouched dividend.
            if (w_load_out) begin
                r_quot_o <= w_dz ? '1 : w_dvd_nxt;
                r_rem_o  <= w_dz ? r_dvd : w_rem_nxt;
                r_dz     <= w_dz;
            end
        end
    end

    assign busy        = (r_state == S_NEG_IN) || (r_state == S_RUN) || (r_state == S_NEG_OUT);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quot_o;
    assign remainder   = r_rem_o;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_div16.sv
// Directed bench for seq_div16 with a behavioural model of the shared add/sub unit.
module tb_seq_div16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic        add_is_sub;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic [16:0] sum17;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign sum17    = {1'b0, add_a} + {1'b0, add_b ^ {16{add_is_sub}}} + 17'(add_cin);
    assign add_sum  = sum17[15:0];
    assign add_cout = sum17[16];

    seq_div16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_is_sub (add_is_sub),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sg);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 60);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic sg, input logic [15:0] eq, input logic [15:0] er,
                             input logic edz, input int elat);
        int n;
        start_op(a, b, sg);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        check("rst_add", {add_a, add_b}, 32'd0);
        check("rst_add_ctl", {30'd0, add_cin, add_is_sub}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_check("d100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17);
        check("idle_add", {add_a, add_b}, 32'd0);
        check("idle_add_ctl", {30'd0, add_cin, add_is_sub}, 32'd0);
        run_check("dffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_check("d5_9", 16'd5, 16'd9, 1'b0, 16'h0000, 16'h0005, 1'b0, 17);
        run_check("dz", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1);
        run_check("d10_3", 16'd10, 16'd3, 1'b0, 16'd3, 16'd1, 1'b0, 17);

        // start while busy must be ignored
        start_op(16'd100, 16'd7, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ign_lat", 32'(n + 5), 32'd17);
        check("ign_q", 32'(quotient), 32'd14);
        check("ign_r", 32'(remainder), 32'd2);

        // start in the DONE cycle is accepted back to back
        dividend = 16'd10;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        wait_done(n);
        check("b2b_lat", 32'(n), 32'd17);
        check("b2b_q", 32'(quotient), 32'd3);
        check("b2b_r", 32'(remainder), 32'd1);

        // asynchronous reset in the middle of an operation
        start_op(16'd1000, 16'd3, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", 32'(quotient), 32'd0);
        check("arst_r", 32'(remainder), 32'd0);
        check("arst_sub", 32'(add_is_sub), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_check("d1000_3", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, 17);

`ifdef SEQ_DIV_SIGNED_EN
        run_check("s_m7_2", 16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 21);
        run_check("s_7_m2", 16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 21);
        run_check("s_min_m1", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 21);
        run_check("s_dz", 16'hFFFB, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFB, 1'b1, 1);
`else
        run_check("u_sgn_ign", 16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0, 17);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
